// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: opcode map,
// sequencer states and the branch-condition helper.
package instr_fetch_sequencer_pkg;

  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_MFI = 3'b001;
  localparam logic [2:0] OP_MW  = 3'b010;
  localparam logic [2:0] OP_MR  = 3'b011;
  localparam logic [2:0] OP_J   = 3'b100;
  localparam logic [2:0] OP_JCE = 3'b101;
  localparam logic [2:0] OP_MB  = 3'b110;
  localparam logic [2:0] OP_JCN = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC
  } state_t;

  // NEQ inverts the sense of the equality test for conditional jumps.
  function automatic logic branch_taken(input logic j, input logic jc,
                                        input logic neq, input logic eq);
    return j | (jc & (eq ^ neq));
  endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Instruction-memory and data-memory handshakes seen by the fetch sequencer.
interface instr_fetch_sequencer_if #(
  parameter int ADDR_W = 8
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [7:0]        imem_data;
  logic              dmem_req;
  logic              dmem_done;

  modport master (
    output imem_req, imem_addr, dmem_req,
    input  imem_ack, imem_data, dmem_done
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req,
    output imem_ack, imem_data, dmem_done
  );

endinterface

// File: rtl/instr_fetch_sequencer_branch_resolve.sv
// Next-PC selection: jump target when the branch is taken, else sequential
// increment wrapping modulo 2^ADDR_W.
module branch_resolve
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_j,
  input  logic              i_jc,
  input  logic              i_neq,
  input  logic              i_eq_flag,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_jump_target,
  output logic [ADDR_W-1:0] o_pc_next
);

  logic w_taken;

  assign w_taken   = branch_taken(i_j, i_jc, i_neq, i_eq_flag);
  assign o_pc_next = w_taken ? i_jump_target : i_pc + ADDR_W'(1);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Non-pipelined fetch/decode/execute sequencer: fetches into the IR, waits
// for data-memory completion and commits the PC with a one-cycle strobe.
module instr_fetch_sequencer
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  instr_fetch_sequencer_if.master  bus,
  output logic [7:0]               instr,
  output logic [2:0]               opcode,
  input  logic                     J,
  input  logic                     JC,
  input  logic                     NEQ,
  input  logic                     RM,
  input  logic                     WM,
  input  logic                     eq_flag,
  input  logic [ADDR_W-1:0]        jump_target,
  output logic                     exec_valid,
  output logic [ADDR_W-1:0]        pc,
  output logic                     busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [7:0]        r_instr;
  logic              w_mem_op;
  logic              w_done;

  branch_resolve #(
    .ADDR_W (ADDR_W)
  ) u_branch_resolve (
    .i_j           (J),
    .i_jc          (JC),
    .i_neq         (NEQ),
    .i_eq_flag     (eq_flag),
    .i_pc          (r_pc),
    .i_jump_target (jump_target),
    .o_pc_next     (w_pc_nxt)
  );

  assign w_mem_op = RM | WM;
  assign w_done   = ~w_mem_op | bus.dmem_done;

  always_comb begin
    w_state_nxt  = r_state;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    exec_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        bus.dmem_req = w_mem_op & ~bus.dmem_done;
        if (w_done) begin
          exec_valid  = 1'b1;
          w_state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FETCH && bus.imem_ack) r_instr <= bus.imem_data;
      if (exec_valid) r_pc <= w_pc_nxt;
    end
  end

  assign bus.imem_addr = r_pc;
  assign instr         = r_instr;
  assign opcode        = r_instr[7:5];
  assign pc            = r_pc;
  assign busy          = (r_state != ST_IDLE);

endmodule
